alu_mul8_seq: RTL and testbench
===============================

ALU_MUL8_SEQ -- requirements
Module: alu_mul8_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a multiply; honoured only in IDLE.
REQ-005 a  input  8  unsigned multiplicand; sampled on the accepting edge only.
REQ-006 b  input  8  unsigned multiplier; sampled on the accepting edge only.
REQ-007 busy  output  1  high while a multiply is in progress (RUN or DONE).
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  16  unsigned a*b; held stable until the next accepted start.
REQ-010 overflow  output  1  product[15:8] nonzero, meaning the result does not fit in 8 bits; held with product.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture a into the multiplicand register, load b into the low accumulator, clear the high accumulator and step counter, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL hold all registers.
REQ-014 Each RUN edge SHALL perform one shift-add step:
- If lo[0]=1, form the 9-bit value {c,s} = hi + mcand using an 8-bit unsigned add with carry-out; otherwise use {0,hi}.
- Update {hi,lo} <= {c, s, lo[7:1]}.
- Increment the 3-bit step counter.
REQ-015 After the 8th RUN step (edge k+8), the FSM SHALL enter DONE; product={hi,lo} becomes valid at that edge.
REQ-016 done SHALL be 1 exactly during the DONE cycle (k+8 to k+9); at edge k+9 the FSM returns to IDLE.
REQ-017 Total latency SHALL be 8 cycles from the accepting edge to done; throughput is one multiply per 9 cycles minimum.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-019 start asserted in RUN or DONE SHALL be ignored with no side effects; the request is not queued.
REQ-020 a and b changes outside the accepting edge SHALL NOT affect the in-flight result.
REQ-021 The carry-out of each step SHALL be kept (9-bit path), so the 16-bit product is exact for all 65536 operand pairs; no truncation or wrap is permitted.
REQ-022 overflow SHALL equal the OR of product[15:8], be registered with product, and update only at the DONE-entry edge.
REQ-023 product and overflow SHALL retain their last values through IDLE and the next RUN, until the next DONE entry.
REQ-024 The step counter SHALL count 0..7 and wrap to 0 on the 8th step; its wrap is the RUN->DONE condition.
REQ-025 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 While rst_n=0, the following SHALL be forced immediately (asynchronously):
- state=IDLE, busy=0, done=0, product=16'h0000, overflow=0.
- All internal registers to 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which rst_n=1 and start=1.

Verification
REQ-029 a=13, b=11, start for 1 cycle -> busy=1 for 9 cycles; done pulses at k+8; product=143 (16'h008F); overflow=0.
REQ-030 a=255, b=255 -> product=65025 (16'hFE01); overflow=1; exercises carry-out on every step.
REQ-031 a=0, b=200, then a=200, b=0 -> product=0 and overflow=0 each time; done still pulses at k+8.
REQ-032 The bench SHALL drive the following while busy: start=1 and a=7, b=9 -> the first result is unaffected, there is no second done, and product is that of the first operands.
REQ-033 a=16, b=16 -> product=256 (16'h0100), overflow=1; then a=1, b=1 -> product=1, overflow=0; previous values are held until the second done.
REQ-034 Pulse rst_n low at k+4 of an a=100, b=3 run -> outputs zero immediately; no done pulse; after release, a=100, b=3 -> product=300 (16'h012C), overflow=1.

Source files
------------

// File: rtl/alu_mul8_seq.sv
// alu_mul8_seq: sequential 8x8 unsigned shift-add multiplier.
// One shift-add step is done per clock. A result is ready 8 cycles after start is accepted.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - multiply request; accepted only in IDLE
//   a, b     - unsigned operands; sampled on the accepting edge only
//   busy     - high while a multiply is in RUN or DONE
//   done     - one-cycle pulse when product is valid
//   product  - 16-bit result; held until the next result is written
//   overflow - product[15:8] is nonzero; held with product
module alu_mul8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        overflow
);

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_n;
  logic [W-1:0]  mcand, mcand_n;
  logic [W-1:0]  hi, hi_n;
  logic [W-1:0]  lo, lo_n;
  logic [SW-1:0] step, step_n;
  logic [2*W-1:0] product_n;
  logic          overflow_n;
  logic          busy_n;
  logic          done_n;
  logic [W:0]    sum;

  // Conditional add. The carry-out is kept as bit W, so no partial sum can wrap.
  always_comb begin
    if (lo[0]) begin
      sum = {1'b0, hi} + {1'b0, mcand};
    end else begin
      sum = {1'b0, hi};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    mcand_n    = mcand;
    hi_n       = hi;
    lo_n       = lo;
    step_n     = step;
    product_n  = product;
    overflow_n = overflow;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          mcand_n = a;
          lo_n    = b;
          hi_n    = '0;
          step_n  = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end

      RUN: begin
        // Shift {carry, sum, lo} right by one. The multiplier bits leave through lo[0].
        hi_n   = sum[W:1];
        lo_n   = {sum[0], lo[W-1:1]};
        step_n = step + SW'(1);
        // The counter wraps on the 8th step. The registered result is written on the same edge.
        if (step == SW'(W - 1)) begin
          product_n  = {sum, lo[W-1:1]};
          overflow_n = |sum[W:1];
          done_n     = 1'b1;
          state_n    = DONE;
        end
      end

      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      step     <= '0;
      product  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      mcand    <= mcand_n;
      hi       <= hi_n;
      lo       <= lo_n;
      step     <= step_n;
      product  <= product_n;
      overflow <= overflow_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_mul8_seq.sv
// tb_alu_mul8_seq: directed, table-driven bench for alu_mul8_seq.
module tb_alu_mul8_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        overflow;

  int unsigned n_pass;
  int unsigned n_total;

  logic [15:0] prev_p;
  logic        prev_o;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        o;
    bit          inject;
  } vec_t;

  vec_t vecs[10];

  alu_mul8_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Run one multiply and check it cycle by cycle.
  // If inj is set, drive start with new operands while busy. That request must be ignored.
  task automatic mul_check(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] ep,
                           input logic eo, input bit inj);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (inj && i == 3) begin
        start = 1'b1; a = 8'd7; b = 8'd9;
      end
      chk("busy_run", 32'(busy), 32'd1);
      if (i < 8) begin
        chk("done_early", 32'(done), 32'd0);
        chk("product_held", 32'(product), 32'(prev_p));
        chk("overflow_held", 32'(overflow), 32'(prev_o));
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("product", 32'(product), 32'(ep));
        chk("overflow", 32'(overflow), 32'(eo));
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
    prev_p = ep;
    prev_o = eo;
    if (inj) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        chk("no_second_done", 32'(done), 32'd0);
        chk("no_second_busy", 32'(busy), 32'd0);
      end
      chk("inject_product", 32'(product), 32'(ep));
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    prev_p  = 16'h0000;
    prev_o  = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F, o: 1'b0, inject: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01, o: 1'b1, inject: 1'b0};
    vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'h0000, o: 1'b0, inject: 1'b0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'h0000, o: 1'b0, inject: 1'b0};
    vecs[4] = '{a: 8'd50,  b: 8'd60,  p: 16'h0BB8, o: 1'b1, inject: 1'b1};
    vecs[5] = '{a: 8'd16,  b: 8'd16,  p: 16'h0100, o: 1'b1, inject: 1'b0};
    vecs[6] = '{a: 8'd1,   b: 8'd1,   p: 16'h0001, o: 1'b0, inject: 1'b0};
    vecs[7] = '{a: 8'd15,  b: 8'd17,  p: 16'h00FF, o: 1'b0, inject: 1'b0};
    vecs[8] = '{a: 8'd128, b: 8'd2,   p: 16'h0100, o: 1'b1, inject: 1'b0};
    vecs[9] = '{a: 8'd1,   b: 8'd255, p: 16'h00FF, o: 1'b0, inject: 1'b0};

    // Values while reset is held
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      mul_check(vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].o, vecs[v].inject);
    end

    // Abort a 100*3 run mid-RUN. Outputs must clear at once, and no done may follow.
    @(negedge clk);
    a = 8'd100; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    prev_p = 16'h0000;
    prev_o = 1'b0;
    mul_check(8'd100, 8'd3, 16'h012C, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
